// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 1 start, DATA_SIZE data LSB first, optional even parity, 1 stop
// Define UART_RX_PARITY_EN to expect and check the even-parity bit after the data bits.
module uart_rx #(
    parameter int CLK_FREQ  = 10000,
    parameter int BAUD_RATE = 1000,
    parameter int DATA_SIZE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [9:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int DIV  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int BW   = $clog2(DATA_SIZE + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [BW-1:0] BITS_M1 = BW'(DATA_SIZE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_next;
    logic                   sync1, sync2, prev;
    logic [1:0]             fill;
    logic                   fall;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_SIZE-1:0]   shreg;
    logic [9:0]             data_q;
    logic                   valid_q, perr_q, ferr_q;
    logic                   cnt_clr, bit_clr, bit_inc, shift_en, par_en, stop_en;
`ifdef UART_RX_PARITY_EN
    logic                   par_acc;
`endif

    // The chain holds its reset values for two clocks; prev only tracks real
    // line samples, so a line held low across reset never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            fill  <= 2'b00;
            prev  <= 1'b0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            prev  <= sync2 & fill[1];
        end
    end

    assign fall = prev & ~sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        bit_clr    = 1'b0;
        bit_inc    = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (fall) state_next = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_clr = 1'b1;
                    bit_clr = 1'b1;
                    state_next = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == DIV_M1) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == BITS_M1) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == DIV_M1) begin
                    cnt_clr    = 1'b1;
                    par_en     = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at the stop-bit centre so a back-to-back start edge is caught.
                if (cnt == DIV_M1) begin
                    cnt_clr    = 1'b1;
                    stop_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc <= 1'b0;
`endif
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (bit_clr)      bit_cnt <= '0;
            else if (bit_inc) bit_cnt <= bit_cnt + BW'(1);
            if (shift_en)
                shreg <= (shreg >> 1) | (DATA_SIZE'(sync2) << (DATA_SIZE - 1));
`ifdef UART_RX_PARITY_EN
            if (par_en) par_acc <= sync2 ^ (^shreg);
`endif
            valid_q <= stop_en;
            if (stop_en) begin
                data_q <= 10'(shreg);
                ferr_q <= ~sync2;
`ifdef UART_RX_PARITY_EN
                perr_q <= par_acc;
`else
                perr_q <= par_en;
`endif
            end
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (frame format follows UART_RX_PARITY_EN)
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int DIV  = 10;
    localparam int HALF = 5;
    localparam int NB   = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int STOP_AT = PAR_EN ? HALF + (NB + 2) * DIV : HALF + (NB + 1) * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [9:0] data_out;
    logic       valid, parity_err, frame_err, busy;

    typedef struct {
        logic [9:0] data;
        logic       perr;
        logic       ferr;
        int         vcyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   nsent = 0;
    int   nvalid = 0;
    bit   prev_v = 1'b0;
    logic [9:0] last_data = '0;

    uart_rx dut (
        .clk(clk), .reset(reset), .rx(rx), .data_out(data_out), .valid(valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; the line is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [9:0] d, input bit par_ok, input bit stop_bit);
        exp_t e;
        logic [7:0] b;
        b = d[7:0];
        e.data = {2'b00, b};
        e.perr = PAR_EN & ~par_ok;
        e.ferr = ~stop_bit;
        e.vcyc = cyc + 2 + STOP_AT + 1;
        q.push_back(e);
        nsent++;
        last_data = e.data;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < NB; i++) begin
            rx = b[i];
            tick(DIV);
        end
        if (PAR_EN) begin
            rx = (^b) ^ ~par_ok;
            tick(DIV);
        end
        rx = stop_bit;
        tick(DIV);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (prev_v) check("valid_width", {31'd0, valid}, 32'd0);
        if (valid) begin
            nvalid++;
            if (q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("data_out", {22'd0, data_out}, {22'd0, e.data});
                check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
                check("valid_cycle", cyc, e.vcyc);
            end
        end
        prev_v = valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_data", {22'd0, data_out}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_flags", {30'd0, parity_err, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick(5);

        send_frame(10'h0A5, 1'b1, 1'b1);
        tick(3);
        check("busy_after_frame", {31'd0, busy}, 32'd0);

        send_frame(10'h007, 1'b0, 1'b1);
        tick(DIV);
        send_frame(10'h03C, 1'b1, 1'b0);
        rx = 1'b1;
        tick(DIV);
        send_frame(10'h055, 1'b1, 1'b1);
        tick(DIV);

        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(1);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        tick(8);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check("glitch_data_hold", {22'd0, data_out}, {22'd0, last_data});
        tick(DIV);

        send_frame(10'h012, 1'b1, 1'b1);
        send_frame(10'h0FE, 1'b1, 1'b1);
        tick(DIV);

        send_frame(10'h000, 1'b1, 1'b0);
        tick(30);
        check("break_no_restart", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        tick(2 * DIV);

        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            tick(DIV);
        end
        rx = 1'b0;
        tick(HALF);
        reset = 1'b0;
        #1;
        last_data = '0;
        check("midrst_data", {22'd0, data_out}, 32'd0);
        check("midrst_outs", {29'd0, valid, parity_err, frame_err}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        tick(3);
        reset = 1'b1;
        tick(40);
        check("low_after_reset_busy", {31'd0, busy}, 32'd0);
        check("low_after_reset_data", {22'd0, data_out}, 32'd0);
        rx = 1'b1;
        tick(2 * DIV);
        send_frame(10'h081, 1'b1, 1'b1);
        tick(DIV);

        for (int i = 0; i < 300 && q.size() != 0; i++) tick(1);
        check("scoreboard_drained", q.size(), 32'd0);
        check("frame_count", nvalid, nsent);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
